// File: rtl/cam_dvp_source.sv
// OV7670-style DVP transmitter: emits pclk/vsync/href/data with RGB565 test patterns.
// All outputs are registered; frame timing advances only on pclk falling edges (ticks).
module cam_dvp_source #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_BLANK       = 144,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_SYNC_LINES  = 3,
  parameter int unsigned V_BACK_LINES  = 17,
  parameter int unsigned V_FRONT_LINES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int unsigned LineLen  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HW       = ($clog2(LineLen) > 8) ? $clog2(LineLen) : 8;
  localparam int unsigned BarPix   = H_ACTIVE / 8;
  localparam int unsigned ActBytes = 2 * H_ACTIVE;

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [15:0]   v_cnt_q, v_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [15:0]   bar_pix_q, bar_pix_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   solid_q, solid_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          phase_q;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;

  logic          tick;
  logic          line_end;
  logic          last_line;
  logic [15:0]   lines_m1;
  logic [15:0]   pix;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    c = 16'h0000;
    case (idx)
      3'd0: c = 16'hFFFF;
      3'd1: c = 16'hFFE0;
      3'd2: c = 16'h07FF;
      3'd3: c = 16'h07E0;
      3'd4: c = 16'hF81F;
      3'd5: c = 16'hF800;
      3'd6: c = 16'h001F;
      3'd7: c = 16'h0000;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  always_comb begin
    lines_m1 = 16'd0;
    unique case (state_q)
      StVsync:  lines_m1 = 16'(V_SYNC_LINES - 1);
      StVback:  lines_m1 = 16'(V_BACK_LINES - 1);
      StActive: lines_m1 = 16'(V_ACTIVE - 1);
      StVfront: lines_m1 = 16'(V_FRONT_LINES - 1);
      default:  lines_m1 = 16'd0;
    endcase
  end

  assign tick      = phase_q;
  assign line_end  = (h_cnt_q == HW'(LineLen - 1));
  assign last_line = (v_cnt_q == lines_m1);

  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    bar_idx_d     = bar_idx_q;
    bar_pix_d     = bar_pix_q;
    pat_d         = pat_q;
    solid_d       = solid_q;
    frame_count_d = frame_count_q;
    vsync_d       = vsync_q;
    href_d        = href_q;
    data_d        = data_q;
    pix           = 16'h0000;

    if (tick) begin
      if (state_q == StIdle) begin
        if (enable) begin
          state_d = StVsync;
          h_cnt_d = '0;
          v_cnt_d = '0;
          pat_d   = pattern_sel;
          solid_d = solid_color;
        end
      end else if (line_end) begin
        h_cnt_d = '0;
        if (last_line) begin
          v_cnt_d = '0;
          unique case (state_q)
            StVsync:  state_d = StVback;
            StVback:  state_d = StActive;
            StActive: state_d = StVfront;
            StVfront: begin
              frame_count_d = frame_count_q + 16'd1;
              if (enable) begin
                state_d = StVsync;
                pat_d   = pattern_sel;
                solid_d = solid_color;
              end else begin
                state_d = StIdle;
              end
            end
            default: state_d = StIdle;
          endcase
        end else begin
          v_cnt_d = v_cnt_q + 16'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end

      // Bar position tracks h_cnt_d; advance one pixel every second byte.
      if (h_cnt_d == '0) begin
        bar_idx_d = '0;
        bar_pix_d = '0;
      end else if (h_cnt_q[0]) begin
        if (bar_pix_q == 16'(BarPix - 1)) begin
          bar_pix_d = '0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_pix_d = bar_pix_q + 16'd1;
        end
      end

      pix     = (pat_q == 2'd1) ? bar_color(bar_idx_d) : solid_q;
      vsync_d = (state_d == StVsync);
      href_d  = (state_d == StActive) && (h_cnt_d < HW'(ActBytes));
      if (!href_d) begin
        data_d = 8'h00;
      end else if (pat_q == 2'd1 || pat_q == 2'd2) begin
        data_d = h_cnt_d[0] ? pix[7:0] : pix[15:8];
      end else begin
        data_d = h_cnt_d[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      bar_idx_q     <= '0;
      bar_pix_q     <= '0;
      pat_q         <= '0;
      solid_q       <= '0;
      frame_count_q <= '0;
      phase_q       <= 1'b0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      bar_idx_q     <= bar_idx_d;
      bar_pix_q     <= bar_pix_d;
      pat_q         <= pat_d;
      solid_q       <= solid_d;
      frame_count_q <= frame_count_d;
      phase_q       <= ~phase_q;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      data_q        <= data_d;
    end
  end

  assign cam_pclk    = phase_q;
  assign cam_vsync   = vsync_q;
  assign cam_href    = href_q;
  assign cam_data    = data_q;
  assign frame_count = frame_count_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_cam_dvp_source.sv
// Self-checking bench for cam_dvp_source: frame-position reference model checked every clk,
// table-driven pattern vectors, directed multi-frame/reset sequences and random stimulus.
module tb_cam_dvp_source;

  localparam int unsigned HA    = 8;
  localparam int unsigned HB    = 4;
  localparam int unsigned VA    = 2;
  localparam int unsigned VS    = 1;
  localparam int unsigned VB    = 1;
  localparam int unsigned VF    = 1;
  localparam int unsigned LL    = 2 * HA + HB;
  localparam int unsigned FRAME = LL * (VS + VB + VA + VF);

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_color;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [15:0] frame_count;
  logic        busy;

  cam_dvp_source #(
    .H_ACTIVE      (HA),
    .H_BLANK       (HB),
    .V_ACTIVE      (VA),
    .V_SYNC_LINES  (VS),
    .V_BACK_LINES  (VB),
    .V_FRONT_LINES (VF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_color (solid_color),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  longint cyc = 0;

  // Reference model: whether a frame is running and the pclk index within it.
  bit          m_phase;
  bit          m_active;
  int          m_pos;
  logic [15:0] m_fc;
  logic [1:0]  m_pat;
  logic [15:0] m_solid;

  logic        prev_vs, prev_href;
  logic [7:0]  prev_data;
  logic [7:0]  cap[$];
  longint      vs_rise[$];

  typedef struct {
    logic [1:0]   pat;
    logic [15:0]  solid;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int h, input logic [1:0] pat,
                                            input logic [15:0] solid);
    logic [127:0] bar_tab;
    logic [15:0]  px;
    int           x;
    bar_tab = 128'hFFFF_FFE0_07FF_07E0_F81F_F800_001F_0000;
    x = h / 2;
    if (pat == 2'd1) px = bar_tab[127 - 16 * (x / (HA / 8)) -: 16];
    else if (pat == 2'd2) px = solid;
    else return 8'(h);
    return (h % 2 == 1) ? px[7:0] : px[15:8];
  endfunction

  task automatic cycle();
    bit   tick;
    int   line, h;
    logic ev, eh;
    logic [7:0] ed;
    tick = 1'b0;
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      m_phase = 0; m_active = 0; m_pos = 0; m_fc = '0; m_pat = '0; m_solid = '0;
    end else begin
      tick    = m_phase;
      m_phase = ~m_phase;
      if (tick) begin
        if (!m_active) begin
          if (enable) begin
            m_active = 1; m_pos = 0; m_pat = pattern_sel; m_solid = solid_color;
          end
        end else begin
          m_pos++;
          if (m_pos == FRAME) begin
            m_fc++;
            m_pos = 0;
            if (enable) begin
              m_pat = pattern_sel; m_solid = solid_color;
            end else begin
              m_active = 0;
            end
          end
        end
      end
    end
    #1;
    line = m_pos / LL;
    h    = m_pos % LL;
    ev   = m_active && (line < VS);
    eh   = m_active && (line >= VS + VB) && (line < VS + VB + VA) && (h < 2 * HA);
    ed   = eh ? model_byte(h, m_pat, m_solid) : 8'h00;
    check("pclk", 32'(cam_pclk), 32'(m_phase));
    check("vsync", 32'(cam_vsync), 32'(ev));
    check("href", 32'(cam_href), 32'(eh));
    check("data", 32'(cam_data), 32'(ed));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("busy", 32'(busy), 32'(m_active));
    check("vsync_href_exclusive", 32'(cam_vsync & cam_href), 32'd0);
    if (reset_n && cam_pclk)
      check("change_off_tick", 32'({cam_vsync, cam_href, cam_data} != {prev_vs, prev_href, prev_data}),
            32'd0);
    if (tick && cam_href) cap.push_back(cam_data);
    if (cam_vsync && !prev_vs) vs_rise.push_back(cyc);
    prev_vs   = cam_vsync;
    prev_href = cam_href;
    prev_data = cam_data;
  endtask

  function automatic logic sigval(input int s);
    case (s)
      0:       return busy;
      1:       return cam_href;
      2:       return frame_count[0];
      default: return vs_rise.size() >= 3;
    endcase
  endfunction

  task automatic wait_for(input int s, input logic val, input int maxc, input string name);
    int n = 0;
    while (sigval(s) !== val && n < maxc) begin
      cycle();
      n++;
    end
    check(name, 32'(sigval(s)), 32'(val));
  endtask

  initial begin
    logic [15:0] fc0;
    logic [7:0]  eb;
    m_phase = 0; m_active = 0; m_pos = 0; m_fc = '0; m_pat = '0; m_solid = '0;
    prev_vs = 0; prev_href = 0; prev_data = '0;
    reset_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0; solid_color = 16'h0000;

    vecs[0] = '{2'd0, 16'h0000, 128'h000102030405060708090A0B0C0D0E0F};
    vecs[1] = '{2'd1, 16'h0000, 128'hFFFFFFE007FF07E0F81FF800001F0000};
    vecs[2] = '{2'd2, 16'h1234, 128'h12341234123412341234123412341234};
    vecs[3] = '{2'd3, 16'h5555, 128'h000102030405060708090A0B0C0D0E0F};

    repeat (3) cycle();
    check("rst_vsync", 32'(cam_vsync), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    reset_n = 1'b1;

    // Idle: pclk runs, everything else quiet.
    repeat (50) cycle();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_fc", 32'(frame_count), 32'd0);

    // One frame per pattern vector; both active lines must match the table.
    for (int i = 0; i < 4; i++) begin
      pattern_sel = vecs[i].pat;
      solid_color = vecs[i].solid;
      cap.delete();
      fc0 = frame_count;
      enable = 1'b1;
      wait_for(0, 1'b1, 10, "vec_start");
      enable = 1'b0;
      wait_for(0, 1'b0, 300, "vec_end");
      check("vec_nbytes", 32'(cap.size()), 32'd32);
      for (int k = 0; k < 32 && k < cap.size(); k++) begin
        eb = vecs[i].exp[127 - 8 * (k % 16) -: 8];
        check($sformatf("vec%0d_byte%0d", i, k), 32'(cap[k]), 32'(eb));
      end
      check("vec_fc", 32'(frame_count), 32'(fc0 + 16'd1));
    end

    // Solid colour changed mid-frame only takes effect on the next frame.
    pattern_sel = 2'd2;
    solid_color = 16'h1234;
    cap.delete();
    enable = 1'b1;
    wait_for(0, 1'b1, 10, "solid_start");
    wait_for(1, 1'b1, 200, "solid_href");
    solid_color = 16'hABCD;
    fc0 = frame_count;
    wait_for(2, ~fc0[0], 300, "solid_frame1_end");
    enable = 1'b0;
    wait_for(0, 1'b0, 300, "solid_end");
    check("solid_nbytes", 32'(cap.size()), 32'd64);
    for (int k = 0; k < 64 && k < cap.size(); k++) begin
      if (k < 32) eb = (k % 2 == 1) ? 8'h34 : 8'h12;
      else eb = (k % 2 == 1) ? 8'hCD : 8'hAB;
      check($sformatf("solid_byte%0d", k), 32'(cap[k]), 32'(eb));
    end

    // Three back-to-back frames, enable dropped during frame 3's active lines.
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    pattern_sel = 2'd1;
    vs_rise.delete();
    enable = 1'b1;
    wait_for(3, 1'b1, 700, "three_vsyncs");
    wait_for(1, 1'b1, 200, "frame3_href");
    enable = 1'b0;
    wait_for(0, 1'b0, 300, "frame3_end");
    check("vsync_count", 32'(vs_rise.size()), 32'd3);
    if (vs_rise.size() >= 3) begin
      check("vsync_spacing_1", 32'(vs_rise[1] - vs_rise[0]), 32'(2 * FRAME));
      check("vsync_spacing_2", 32'(vs_rise[2] - vs_rise[1]), 32'(2 * FRAME));
    end
    check("three_fc", 32'(frame_count), 32'd3);
    check("three_busy", 32'(busy), 32'd0);

    // One-clk reset in the middle of an active line.
    enable = 1'b1;
    wait_for(1, 1'b1, 300, "midline_href");
    reset_n = 1'b0;
    cycle();
    check("mid_rst_pclk", 32'(cam_pclk), 32'd0);
    check("mid_rst_vsync", 32'(cam_vsync), 32'd0);
    check("mid_rst_href", 32'(cam_href), 32'd0);
    check("mid_rst_data", 32'(cam_data), 32'd0);
    check("mid_rst_fc", 32'(frame_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    cycle();
    check("post_rst_no_tick", 32'(cam_vsync), 32'd0);
    cycle();
    check("post_rst_vsync", 32'(cam_vsync), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    wait_for(0, 1'b0, 300, "post_rst_end");

    // Random stimulus against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 199) == 0) pattern_sel = 2'($urandom);
      if ($urandom_range(0, 99) == 0) solid_color = 16'($urandom);
      reset_n = ($urandom_range(0, 1499) != 0);
      cycle();
    end
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
